// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for the streaming FFT datapath.
// Owns the shared sample index, gates datapath advance, runs the input
// handshake for a programmed number of frames, flushes the pipeline and
// tags output samples with valid/last/end.
//
// state | meaning
// IDLE  | waiting for start; datapath frozen, cnt held at 0
// RUN   | accepting samples; en follows in_valid
// FLUSH | LAT enabled steps with no input to drain the datapath
module fft_frame_ctrl #(
  parameter int CBW = 3,
  parameter int LAT = 4,
  parameter int NFW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NFW-1:0] nfrm,
  input  logic           abort,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [CBW-1:0] cnt,
  output logic           en,
  output logic           out_valid,
  output logic           out_last,
  output logic           out_end,
  output logic           busy,
  output logic           done
);

  localparam logic [CBW-1:0] CNT_MAX = '1;
  localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t         state, state_nxt;
  logic [NFW-1:0] frames_left;
  logic [FW-1:0]  flush_cnt;
  logic [LAT-1:0] tag_v, tag_last, tag_end;
  logic           accept, at_wrap, last_frame, start_ok, flush_tc;

  assign accept     = (state == S_RUN) & in_valid;
  assign at_wrap    = (cnt == CNT_MAX);
  assign last_frame = (frames_left == NFW'(1));
  assign start_ok   = (state == S_IDLE) & start & ~abort;
  assign flush_tc   = (state == S_FLUSH) & (flush_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok && nfrm != '0) state_nxt = S_RUN;
      S_RUN:   if (accept && at_wrap && last_frame) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Outputs decoded from state; en and tags are combinational from in_valid in RUN
  always_comb begin
    in_ready  = (state == S_RUN);
    busy      = (state != S_IDLE);
    en        = accept | (state == S_FLUSH);
    out_valid = en & tag_v[LAT-1];
    out_last  = out_valid & tag_last[LAT-1];
    out_end   = out_valid & tag_end[LAT-1];
  end

  // Sample index: advances with every enabled step, returns to 0 when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (abort)         cnt <= '0;
    else if (flush_tc)      cnt <= '0;
    else if (en)            cnt <= cnt + CBW'(1);
  end

  // Remaining-frame count; decrements on the last sample of each frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     frames_left <= '0;
    else if (abort)                              frames_left <= '0;
    else if (start_ok && nfrm != '0)             frames_left <= nfrm;
    else if (accept && at_wrap && frames_left != '0)
                                                 frames_left <= frames_left - NFW'(1);
  end

  // Flush timer: preloaded while running, counts down to terminal 0 in FLUSH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 flush_cnt <= FW'(LAT - 1);
    else if (state == S_RUN)                 flush_cnt <= FW'(LAT - 1);
    else if (state == S_FLUSH && !flush_tc)  flush_cnt <= flush_cnt - FW'(1);
  end

  // Tag pipeline mirrors datapath latency; shifts only on enabled steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v    <= '0;
      tag_last <= '0;
      tag_end  <= '0;
    end else if (abort) begin
      tag_v    <= '0;
      tag_last <= '0;
      tag_end  <= '0;
    end else if (en) begin
      tag_v    <= LAT'({tag_v, accept});
      tag_last <= LAT'({tag_last, accept & at_wrap});
      tag_end  <= LAT'({tag_end, accept & at_wrap & last_frame});
    end
  end

  // Done pulse: after the final flush step, or immediately for an empty job
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        done <= 1'b0;
    else if (abort) done <= 1'b0;
    else            done <= flush_tc | (start_ok & (nfrm == '0));
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl. Expected outputs come from an
// arithmetic job model: per job, the count of enabled steps e determines
// everything (cnt = e mod N, accepts are steps 0..F*N-1, flush steps follow,
// output tag for step e belongs to sample e-LAT).
module tb_fft_frame_ctrl;
  localparam int CBW = 3;
  localparam int LAT = 4;
  localparam int NFW = 8;
  localparam int N   = 1 << CBW;

  logic           clk = 1'b0;
  logic           rst, start, abort, in_valid;
  logic [NFW-1:0] nfrm;
  logic           in_ready, en, out_valid, out_last, out_end, busy, done;
  logic [CBW-1:0] cnt;

  fft_frame_ctrl #(.CBW(CBW), .LAT(LAT), .NFW(NFW)) dut (
    .clk(clk), .rst(rst), .start(start), .nfrm(nfrm), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .cnt(cnt), .en(en),
    .out_valid(out_valid), .out_last(out_last), .out_end(out_end),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_busy = 0;
  bit m_done = 0;
  int m_f    = 0;
  int m_e    = 0;
  bit m_en   = 0;

  // observed outputs of the most recent cycle
  logic s_done, s_ov, s_ol;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int tot, idx;
    bit e_ready, e_ov, e_ol, e_oe;
    int e_cnt;
    tot     = m_f * N;
    e_ready = m_busy && (m_e < tot);
    m_en    = m_busy && ((m_e < tot) ? in_valid : 1'b1);
    e_cnt   = m_busy ? (m_e % N) : 0;
    idx     = m_e - LAT;
    e_ov    = m_en && (idx >= 0) && (idx < tot);
    e_ol    = e_ov && ((idx % N) == N - 1);
    e_oe    = e_ov && (idx == tot - 1);
    chk("busy",      32'(busy),      32'(m_busy));
    chk("in_ready",  32'(in_ready),  32'(e_ready));
    chk("en",        32'(en),        32'(m_en));
    chk("cnt",       32'(cnt),       32'(e_cnt));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_last",  32'(out_last),  32'(e_ol));
    chk("out_end",   32'(out_end),   32'(e_oe));
    chk("done",      32'(done),      32'(m_done));
  endtask

  task automatic model_update();
    if (rst || abort) begin
      m_busy = 0; m_done = 0; m_e = 0;
    end else if (m_busy) begin
      m_done = 0;
      if (m_en) m_e++;
      if (m_e == m_f * N + LAT) begin
        m_busy = 0; m_done = 1; m_e = 0;
      end
    end else begin
      m_done = start && (nfrm == '0);
      if (start && nfrm != '0) begin
        m_busy = 1; m_f = int'(nfrm); m_e = 0;
      end
    end
  endtask

  // One clock cycle: check at the falling edge, advance model, drive after rising edge
  task automatic cyc();
    @(negedge clk);
    s_done = done; s_ov = out_valid; s_ol = out_last;
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_at, nv, nl;
    int lp [2];
    rst = 1; start = 0; abort = 0; in_valid = 0; nfrm = '0;
    repeat (3) cyc();
    rst = 0;
    repeat (2) cyc();

    // continuous nfrm=2
    start = 1; nfrm = 2; in_valid = 1; cyc(); start = 0;
    done_at = -1; nv = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (s_ov) nv++;
      if (s_done && done_at < 0) done_at = i;
    end
    chk("cont_done_cycle", done_at, 20);
    chk("cont_valid_count", nv, 16);

    // same job with stalls on cycles 3,4,10
    start = 1; nfrm = 2; cyc(); start = 0;
    done_at = -1; nv = 0; nl = 0; lp[0] = 0; lp[1] = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = !(i == 3 || i == 4 || i == 10);
      cyc();
      if (s_ov) nv++;
      if (s_ol && nl < 2) begin lp[nl] = nv; nl++; end
      if (s_done && done_at < 0) done_at = i;
    end
    in_valid = 1;
    chk("stall_done_cycle", done_at, 23);
    chk("stall_valid_count", nv, 16);
    chk("stall_last0_pos", lp[0], 8);
    chk("stall_last1_pos", lp[1], 16);

    // empty job
    start = 1; nfrm = 0; cyc(); start = 0;
    cyc();
    chk("empty_done", 32'(s_done), 1);
    repeat (3) cyc();

    // abort at cycle 6 of a 3-frame job, then a clean 1-frame job
    start = 1; nfrm = 3; cyc(); start = 0;
    for (int i = 0; i < 7; i++) begin
      abort = (i == 6);
      cyc();
    end
    abort = 0;
    repeat (3) cyc();
    start = 1; nfrm = 1; cyc(); start = 0;
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_done && done_at < 0) done_at = i;
    end
    chk("post_abort_done_cycle", done_at, 8 + LAT);

    // abort and start in the same idle cycle: abort wins
    start = 1; abort = 1; nfrm = 2; cyc(); start = 0; abort = 0;
    repeat (3) cyc();

    // asynchronous reset mid-flush
    start = 1; nfrm = 1; cyc(); start = 0;
    for (int i = 0; i < 40 && m_e < N + 1; i++) cyc();
    #2 rst = 1;
    m_busy = 0; m_done = 0; m_e = 0;
    #1 check_all();
    start = 1; nfrm = 2;
    repeat (3) cyc();
    start = 0; rst = 0;
    repeat (6) cyc();

    // start pulses while busy with a different nfrm
    start = 1; nfrm = 2; cyc(); start = 0;
    done_at = -1;
    for (int i = 0; i < 30; i++) begin
      start = (i == 2 || i == 5);
      nfrm  = start ? 8'd7 : 8'd2;
      cyc();
      if (s_done && done_at < 0) done_at = i;
    end
    start = 0;
    chk("busy_start_done_cycle", done_at, 20);

    // maximum frame count
    start = 1; nfrm = 8'd255; in_valid = 1; cyc(); start = 0;
    done_at = -1;
    for (int i = 0; i < 2100 && done_at < 0; i++) begin
      cyc();
      if (s_done) done_at = i;
    end
    chk("max_nfrm_done_cycle", done_at, 255 * N + LAT);

    // randomized jobs
    for (int j = 0; j < 40; j++) begin
      start = 1; nfrm = NFW'($urandom_range(0, 4)); cyc();
      start = 0;
      for (int c = 0; c < 400 && (m_busy || m_done); c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        abort    = ($urandom_range(0, 199) == 0);
        start    = ($urandom_range(0, 9) == 0);
        nfrm     = NFW'($urandom_range(0, 3));
        cyc();
      end
      start = 0; abort = 0;
      cyc();
      chk("rand_job_timeout", 32'(busy | m_busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the streaming FFT datapath. Owns the sample-index counter `cnt` that every stage in the chain (half-rate reorder buffers, butterflies) decodes. It also gates datapath advance with a clock enable, runs the input handshake for a programmed number of frames, flushes the pipeline and tags output samples with valid/last.

## Interface

Parameters:
- CBW, 3, counter width; frame length N = 2^CBW samples.
- LAT, 4, datapath latency in enabled steps (en-cycles) from input sample to its output; LAT >= 1.
- NFW, 8, width of the frame-count field.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a job; sampled only in IDLE.
- nfrm  input  NFW  frames in the job; latched when start is accepted.
- abort  input  1  synchronous cancel; wins over every other event.
- in_valid  input  1  upstream sample present on datapath din.
- in_ready  output  1  controller accepts samples; registered, equals (state==RUN).
- cnt  output  CBW  sample index for the datapath; index of the sample on din this cycle.
- en  output  1  datapath advance enable; all chain registers update only when en=1.
- out_valid  output  1  datapath dout carries a real sample this cycle.
- out_last  output  1  out_valid sample is index N-1 of its frame.
- out_end  output  1  out_valid sample is the final sample of the job.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the job fully drains.

## Operation

- States: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready=0, en=0, cnt held at 0.
  - start with nfrm!=0: latch nfrm into frames_left, go to RUN next cycle.
  - start with nfrm==0: no RUN. done pulses next cycle. State stays IDLE.
- RUN:
  - accept = in_valid (in_ready=1). en = accept. cnt increments mod N on each accept.
  - in_valid=0 stalls: cnt, pipeline and tags hold. Stalls are legal at any index.
  - Accept at cnt==N-1 decrements frames_left. If frames_left was 1, go to FLUSH.
- FLUSH:
  - in_ready=0, en=1 every cycle for exactly LAT cycles.
  - cnt keeps incrementing mod N so stage decoders stay in step; din is don't-care.
  - Then go to IDLE. done asserts in the following cycle.
- Tag pipeline: three LAT-deep shift registers (v, last, end) shift only when en=1.
  - Stage 0 inputs: accept; accept & cnt==N-1; accept & cnt==N-1 & frames_left==1.
  - out_valid = en & v[LAT-1]. out_last = out_valid & last[LAT-1]. out_end = out_valid & end[LAT-1].
- Widths: cnt wraps silently. frames_left is NFW bits, decrement only from nonzero. nfrm = 2^NFW-1 is legal.
- start while busy: ignored, no latch.
- abort (any state):
  - Next cycle: IDLE, cnt=0, tag pipeline cleared, frames_left=0, no done pulse.
  - abort and start in the same IDLE cycle: abort wins, job not started.
- Reset (asynchronous, mid-job included): state IDLE, cnt=0, frames_left=0, tag pipeline cleared, done=0.
  - All outputs 0 while rst=1 and after release until a new start.

## Timing

- Cycle 0 = first cycle in RUN (start sampled at the edge before it).
- in_ready rises at cycle 0 and falls in the cycle after the last accept.
- Continuous input, nfrm=F: accepts at cycles 0..F·N-1; FLUSH at F·N..F·N+LAT-1; done at F·N+LAT with busy=0.
- out_valid for the k-th accepted sample occurs LAT en-cycles after its accept. With no stalls this is cycle k+LAT.
- No combinational path from in_valid to in_ready. en and out_valid are combinational from in_valid in RUN.
- done: single cycle, registered.

## Test plan

- CBW=3, LAT=4, nfrm=2, in_valid held 1:
  - cnt runs 0..7,0..7 on cycles 0..15, then 0..3 on 16..19.
  - out_valid on 4..19; out_last on 11 and 19; out_end on 19 only.
  - done on 20; busy low from 20.
- Same job with in_valid low on cycles 3,4 and 10:
  - cnt holds through stalls; en low on those cycles.
  - out_valid count exactly 16; out_last on the 8th and 16th valid outputs.
  - done 3 cycles later than the stall-free run.
- start with nfrm=0: done pulses next cycle, busy never rises, en never asserts.
- abort at cycle 6 of nfrm=3:
  - Cycle 7: IDLE, cnt=0, in_ready=0, no out_valid, no done.
  - A new start with nfrm=1 then runs a clean 8+LAT cycle job.
- rst asserted asynchronously mid-FLUSH:
  - All outputs 0 immediately.
  - After release, start is ignored until sampled in IDLE. No stale out_valid from the old tags.
- start pulsed while busy (cycles 2 and 5) with a different nfrm: no effect on the frame count or done timing.
